// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default limits for the MM:SS
// countdown timer (countdown_timer, down_counter).
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_SEC_MAX = 59;
    localparam int DEF_MIN_MAX = 59;

endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter that borrows at zero, reloading
// MAX_VAL; zB flags a decrement taken while the count is zero.
module down_counter #(
    parameter int BITS    = 6,
    parameter int MAX_VAL = 59
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [BITS-1:0] d,
    input  logic            dec,
    output logic [BITS-1:0] count,
    output logic            zB
);

    logic [BITS-1:0] r_count;

    assign count = r_count;
    assign zB    = dec && (r_count == '0);

    // Load wins over decrement; a decrement at zero borrows to MAX_VAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (ld) begin
            r_count <= d;
        end else if (dec) begin
            r_count <= (r_count == '0) ? BITS'(MAX_VAL) : r_count - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: two-stage MM:SS countdown with IDLE/RUN/PAUSE/DONE FSM.
// Optional COUNTDOWN_AUTO_RELOAD_EN: reload the last load value at expiry.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int SEC_BITS = 6,
    parameter int MIN_BITS = 6,
    parameter int SEC_MAX  = DEF_SEC_MAX,
    parameter int MIN_MAX  = DEF_MIN_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                load,
    input  logic [MIN_BITS-1:0] load_min,
    input  logic [SEC_BITS-1:0] load_sec,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    output logic [MIN_BITS-1:0] min,
    output logic [SEC_BITS-1:0] sec,
    output logic                running,
    output logic                done,
    output logic                expired
);

    localparam logic [SEC_BITS-1:0] LP_SEC_MAX = SEC_BITS'(SEC_MAX);
    localparam logic [MIN_BITS-1:0] LP_MIN_MAX = MIN_BITS'(MIN_MAX);

    state_t              r_state;
    state_t              w_nxt;
    logic                r_running;
    logic                r_done;
    logic                r_expired;
    logic [MIN_BITS-1:0] w_min;
    logic [SEC_BITS-1:0] w_sec;
    logic [MIN_BITS-1:0] w_d_min;
    logic [SEC_BITS-1:0] w_d_sec;
    logic [MIN_BITS-1:0] w_cl_min;
    logic [SEC_BITS-1:0] w_cl_sec;
    logic                w_ld;
    logic                w_dec;
    logic                w_sec_zb;
    logic                w_unused_min_zb;
    logic                w_zero;
    logic                w_last;
    logic                w_take_load;
    logic                w_expire;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [MIN_BITS-1:0] r_sh_min;
    logic [SEC_BITS-1:0] r_sh_sec;
    logic                w_sh_zero;

    assign w_sh_zero = (r_sh_min == '0) && (r_sh_sec == '0);
`endif

    assign w_cl_min    = (load_min > LP_MIN_MAX) ? LP_MIN_MAX : load_min;
    assign w_cl_sec    = (load_sec > LP_SEC_MAX) ? LP_SEC_MAX : load_sec;
    assign w_zero      = (w_min == '0) && (w_sec == '0);
    assign w_last      = (w_min == '0) && (w_sec == SEC_BITS'(1));
    assign w_take_load = !clear && load && (r_state != ST_RUN);

    // Command priority clear > load > stop > start > tick; ignored ones fall through
    always_comb begin
        w_nxt    = r_state;
        w_ld     = 1'b0;
        w_d_min  = '0;
        w_d_sec  = '0;
        w_dec    = 1'b0;
        w_expire = 1'b0;
        if (clear) begin
            w_nxt = ST_IDLE;
            w_ld  = 1'b1;
        end else if (w_take_load) begin
            w_nxt   = ST_IDLE;
            w_ld    = 1'b1;
            w_d_min = w_cl_min;
            w_d_sec = w_cl_sec;
        end else if (stop && (r_state == ST_RUN)) begin
            w_nxt = ST_PAUSE;
        end else if (start && !w_zero &&
                     ((r_state == ST_IDLE) || (r_state == ST_PAUSE))) begin
            w_nxt = ST_RUN;
        end else if (tick && (r_state == ST_RUN)) begin
            w_dec = 1'b1;
            if (w_last) begin
                w_expire = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (!w_sh_zero) begin
                    w_dec   = 1'b0;
                    w_ld    = 1'b1;
                    w_d_min = r_sh_min;
                    w_d_sec = r_sh_sec;
                end else begin
                    w_nxt = ST_DONE;
                end
`else
                w_nxt = ST_DONE;
`endif
            end
        end
    end

    down_counter #(
        .BITS    (SEC_BITS),
        .MAX_VAL (SEC_MAX)
    ) u_sec (
        .clk   (clk),
        .rst   (rst),
        .ld    (w_ld),
        .d     (w_d_sec),
        .dec   (w_dec),
        .count (w_sec),
        .zB    (w_sec_zb)
    );

    down_counter #(
        .BITS    (MIN_BITS),
        .MAX_VAL (MIN_MAX)
    ) u_min (
        .clk   (clk),
        .rst   (rst),
        .ld    (w_ld),
        .d     (w_d_min),
        .dec   (w_sec_zb),
        .count (w_min),
        .zB    (w_unused_min_zb)
    );

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Shadow keeps the last accepted (clamped) load for auto-reload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_min <= '0;
            r_sh_sec <= '0;
        end else if (w_take_load) begin
            r_sh_min <= w_cl_min;
            r_sh_sec <= w_cl_sec;
        end
    end
`endif

    // State register with registered status decodes and expiry pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_running <= (w_nxt == ST_RUN);
            r_done    <= (w_nxt == ST_DONE);
            r_expired <= w_expire;
        end
    end

    assign min     = w_min;
    assign sec     = w_sec;
    assign running = r_running;
    assign done    = r_done;
    assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench; a total-seconds reference model
// queues expected outputs, a monitor compares them every cycle.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] min;
    logic [5:0] sec;
    logic       running;
    logic       done;
    logic       expired;

    int nvec = 0;
    int nbad = 0;

    typedef struct {
        int mn;
        int sc;
        bit run;
        bit dn;
        bit ex;
    } exp_t;

    exp_t q[$];

    // Reference model: whole count kept as total seconds
    int m_t  = 0;
    int m_sh = 0;
    int m_st = 0;

    countdown_timer dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .min      (min),
        .sec      (sec),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input exp_t e);
        nvec++;
        if (min !== 6'(e.mn) || sec !== 6'(e.sc) || running !== e.run ||
            done !== e.dn || expired !== e.ex) begin
            nbad++;
            $display("FAIL %s @%0t: got %0d:%0d run=%b done=%b exp=%b, want %0d:%0d run=%b done=%b exp=%b",
                     nm, $time, min, sec, running, done, expired,
                     e.mn, e.sc, e.run, e.dn, e.ex);
        end
    endtask

    function automatic void model(input bit tk, input bit ld, input int lm,
                                  input int ls, input bit st, input bit sp,
                                  input bit cl);
        exp_t e;
        bit   ex;
        ex = 1'b0;
        if (cl) begin
            m_st = 0;
            m_t  = 0;
        end else if (ld && m_st != 1) begin
            m_t  = ((lm > 59) ? 59 : lm) * 60 + ((ls > 59) ? 59 : ls);
            m_sh = m_t;
            m_st = 0;
        end else if (sp && m_st == 1) begin
            m_st = 2;
        end else if (st && (m_st == 0 || m_st == 2) && m_t != 0) begin
            m_st = 1;
        end else if (tk && m_st == 1) begin
            m_t = m_t - 1;
            if (m_t == 0) begin
                ex = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (m_sh != 0) m_t = m_sh;
                else m_st = 3;
`else
                m_st = 3;
`endif
            end
        end
        e.mn  = m_t / 60;
        e.sc  = m_t % 60;
        e.run = (m_st == 1);
        e.dn  = (m_st == 3);
        e.ex  = ex;
        q.push_back(e);
    endfunction

    task automatic step(input bit tk, input bit ld, input int lm, input int ls,
                        input bit st, input bit sp, input bit cl);
        @(negedge clk);
        tick     = tk;
        load     = ld;
        load_min = 6'(lm);
        load_sec = 6'(ls);
        start    = st;
        stop     = sp;
        clear    = cl;
        model(tk, ld, lm, ls, st, sp, cl);
        @(posedge clk);
        #1;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_tick();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_load(input int m, input int s);
        step(0, 1, m, s, 0, 0, 0);
    endtask

    task automatic do_start();
        step(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic do_idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected vector per clocked stimulus cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("cycle", e);
            end
        end
    end

    initial begin
        exp_t z;
        z.mn = 0; z.sc = 0; z.run = 0; z.dn = 0; z.ex = 0;

        #12;
        cmp("reset_state", z);
        @(negedge clk);
        rst = 1'b0;

        // 0:03 down to expiry, then a tick in DONE holds 0:00
        do_load(0, 3);
        do_start();
        repeat (3) begin
            do_tick();
            do_idle();
        end
        do_tick();
        do_idle();

        // Borrow from 2:00 and run the full two minutes
        do_load(2, 0);
        do_start();
        repeat (120) do_tick();
        do_idle();
        do_idle();

        // Saturating clamp, then load ignored while running
        do_load(63, 63);
        do_load(60, 5);
        do_load(7, 60);
        do_start();
        do_load(1, 1);
        do_tick();

        // stop+tick: stop wins; resume; clear
        do_load(0, 10);
        do_start();
        step(1, 0, 0, 0, 0, 1, 0);
        do_tick();
        do_start();
        do_tick();
        step(0, 0, 0, 0, 0, 0, 1);

        // start with 0:00 stays idle; start in DONE ignored
        do_start();
        do_tick();
        do_load(0, 1);
        do_start();
        do_tick();
        do_start();
        do_tick();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Auto-reload period of 0:02 repeated several times
        do_load(0, 2);
        do_start();
        repeat (7) do_tick();
        step(0, 0, 0, 0, 0, 0, 1);
`endif

        // Async reset mid-RUN at 1:30
        do_load(1, 31);
        do_start();
        do_tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_rst", z);
        @(posedge clk);
        #1;
        cmp("rst_hold", z);
        @(negedge clk);
        rst  = 1'b0;
        m_t  = 0;
        m_sh = 0;
        m_st = 0;

        // Randomized command mix
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                             : $urandom_range(0, 1),
                 $urandom_range(0, 63),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 79) == 0);
        end

        repeat (3) @(posedge clk);
        #3;
        nvec++;
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL drain: %0d expected vectors left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
